// File: rtl/banked_reg_file.sv
// rtl/banked_reg_file.sv - banked register file with sweep clear, writeback bypass and bank select
module banked_reg_file #(
    parameter int NUM_BANKS = 4,
    parameter int DATA_W    = 16
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              wbEnable_i,
    input  logic [4:0]        wbAddress_i,
    input  logic [DATA_W-1:0] wbData_i,
    input  logic [5:0]        wbBank_i,
    input  logic              bankUpdate_i,
    input  logic [5:0]        bankValue_i,
    input  logic              readEnable_i,
    input  logic [4:0]        pAddress_i,
    input  logic [4:0]        sAddress_i,
    output logic [DATA_W-1:0] pOperand_o,
    output logic [DATA_W-1:0] sOperand_o,
    output logic              readValid_o,
    output logic [5:0]        regBankSelect_o,
    output logic              ready_o,
    output logic              wbDropped_o,
    output logic              bankFault_o
);

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int IDX_W  = BANK_W + 5;
    localparam int DEPTH  = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BANKS * 32 - 1);
    localparam logic [6:0]       BANK_LIMIT = 7'(NUM_BANKS);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  clear_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              running;
    logic              wb_bank_ok;
    logic              bank_value_ok;
    logic              wb_legal;
    logic              p_hit;
    logic              s_hit;
    logic [IDX_W-1:0]  wb_idx;
    logic [IDX_W-1:0]  p_idx;
    logic [IDX_W-1:0]  s_idx;

    assign running       = (state == RUN);
    assign wb_bank_ok    = ({1'b0, wbBank_i} < BANK_LIMIT);
    assign bank_value_ok = ({1'b0, bankValue_i} < BANK_LIMIT);
    assign wb_legal      = running && wbEnable_i && wb_bank_ok;

    // Index slices are only meaningful once the bank has been range-checked.
    assign wb_idx = {wbBank_i[BANK_W-1:0], wbAddress_i};
    assign p_idx  = {regBankSelect_o[BANK_W-1:0], pAddress_i};
    assign s_idx  = {regBankSelect_o[BANK_W-1:0], sAddress_i};

    // Same-cycle writeback into the bank being read forwards the new data.
    assign p_hit = wb_legal && (wbBank_i == regBankSelect_o) && (wbAddress_i == pAddress_i);
    assign s_hit = wb_legal && (wbBank_i == regBankSelect_o) && (wbAddress_i == sAddress_i);

    assign ready_o = running;

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clear_idx == LAST_IDX) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state     <= CLEAR;
            clear_idx <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) clear_idx <= clear_idx + 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            if (state == CLEAR) mem[clear_idx] <= '0;
            else if (wb_legal)  mem[wb_idx]    <= wbData_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pOperand_o      <= '0;
            sOperand_o      <= '0;
            readValid_o     <= 1'b0;
            regBankSelect_o <= '0;
            wbDropped_o     <= 1'b0;
            bankFault_o     <= 1'b0;
        end else begin
            readValid_o <= running && readEnable_i;
            wbDropped_o <= running && wbEnable_i && !wb_bank_ok;
            if (running && readEnable_i) begin
                pOperand_o <= p_hit ? wbData_i : mem[p_idx];
                sOperand_o <= s_hit ? wbData_i : mem[s_idx];
            end
            if (running && bankUpdate_i) begin
                if (bank_value_ok) regBankSelect_o <= bankValue_i;
                else               bankFault_o     <= 1'b1;
            end
        end
    end

endmodule
